ram_arb_ctrl: RTL
=================

RAM_ARB_CTRL -- requirements
Module: ram_arb_ctrl

Interface
REQ-001 Parameter WeightI, default 1: max consecutive grants to the instruction host under contention (range 1..15).
REQ-002 Parameter WeightD, default 2: max consecutive grants to the data host under contention (range 1..15).
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 tl_corei_i  input  tlul_pkg::tl_h2d_t  instruction host request.
REQ-006 tl_corei_o  output  tlul_pkg::tl_d2h_t  instruction host response.
REQ-007 tl_cored_i  input  tlul_pkg::tl_h2d_t  data host request (RAM-decoded only).
REQ-008 tl_cored_o  output  tlul_pkg::tl_d2h_t  data host response.
REQ-009 tl_ram_o  output  tlul_pkg::tl_h2d_t  request to RAM device.
REQ-010 tl_ram_i  input  tlul_pkg::tl_d2h_t  response from RAM device.
REQ-011 gnt_o  output  2  one-hot owner, bit0 = corei, bit1 = cored; 0 when IDLE.
REQ-012 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, ADDR, RESP; only one transaction outstanding at a time.
REQ-014 IDLE: if any host a_valid=1, latch owner per REQ-017 and go to ADDR next cycle; arbitration latency is one cycle.
REQ-015 ADDR: tl_ram_o = owner's h2d struct; owner a_ready = tl_ram_i.a_ready; on a_valid&&a_ready go to RESP, or to IDLE if d_valid&&d_ready in the same cycle.
REQ-016 RESP: owner d2h fields = tl_ram_i; tl_ram_o.d_ready = owner d_ready, tl_ram_o.a_valid = 0; on d_valid&&d_ready go to IDLE.
REQ-017 Arbitration: single requester wins; under contention the host indicated by prio wins.
REQ-018 Per grant: if owner equals previous owner, burst_cnt+1 (saturating at 15), else burst_cnt = 1.
REQ-019 After the update, prio flips to the other host when burst_cnt >= weight of owner; otherwise prio is unchanged.
REQ-020 Non-owner host always sees a_ready=0 and d_valid=0; an unselected a_valid is never lost, only stalled.
REQ-021 In IDLE, tl_ram_o drives all-zero except d_ready=0, and both hosts see a_ready=0 and d_valid=0.
REQ-022 The d2h struct is routed unchanged (including d_source, d_error) to the owner.
REQ-023 RAM d_valid arriving in IDLE is ignored (d_ready=0); RAM must not issue it.

Reset
REQ-024 Under rst_i: state=IDLE, prio=cored, burst_cnt=0, prev owner=cored, gnt_o=0, busy_o=0.
REQ-025 Under rst_i, all a_valid, a_ready, d_valid and d_ready outputs are 0 in the same cycle.
REQ-026 Reset asserted in ADDR or RESP aborts the transaction; no response is forwarded after reset.

Structure
REQ-027 Package ram_arb_pkg holds the state enum (IDLE/ADDR/RESP), the host index constants HostI=0 and HostD=1, and the 4-bit burst counter type.
REQ-028 The weighted picker (prio, burst_cnt, prev owner) is one sub-module, ram_arb_wrr; the FSM and muxing stay in ram_arb_ctrl.
REQ-029 Output muxing is combinational from registered state and owner; no FIFOs.

Verification
REQ-030 corei alone, RAM a_ready=1 and d_valid one cycle later -> gnt_o=01 in the cycle after a_valid; d2h returned to corei; back in IDLE after 3 cycles.
REQ-031 Both hosts requesting continuously, defaults -> grant order D,D,I,D,D,I...
REQ-032 WeightI=3, WeightD=1, continuous contention -> order D,I,I,I,D,I,I,I.
REQ-033 RAM holds a_ready=0 for 5 cycles in ADDR -> owner sees a_ready=0 for those 5 cycles; the other host stays stalled with a_ready=0; gnt_o stable.
REQ-034 RAM a_ready=1 and d_valid=1 in the same ADDR cycle with owner d_ready=1 -> return to IDLE next cycle with no RESP state.
REQ-035 rst_i pulsed in RESP while d_valid=1 -> next cycle IDLE, all valid/ready outputs 0, prio=cored.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding, host indices and burst counter type
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, RESP = 2'd2} state_e;
  localparam logic HostI = 1'b0;
  localparam logic HostD = 1'b1;
  typedef logic [3:0] burst_t;
endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: minimal TileLink-UL request/response structs shared by hosts and RAM
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/ram_arb_wrr.sv
// ram_arb_wrr: weighted picker between instruction and data hosts
module ram_arb_wrr
  import ram_arb_pkg::*;
#(
  parameter int WeightI = 1,
  parameter int WeightD = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       take,
  output logic       win
);
  logic   prio, prev;
  burst_t burst, burst_nxt;
  burst_t weight;
  always_comb begin
    win       = req == 2'b01 ? HostI : req == 2'b10 ? HostD : prio;
    burst_nxt = win != prev ? burst_t'(1) : burst == 4'hf ? burst : burst + 4'd1;
    weight    = win == HostD ? burst_t'(WeightD) : burst_t'(WeightI);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio  <= HostD;
      prev  <= HostD;
      burst <= '0;
    end else if (take) begin
      prev  <= win;
      burst <= burst_nxt;
      if (burst_nxt >= weight) prio <= ~win;
    end
  end
endmodule

// File: rtl/ram_arb_ctrl.sv
// ram_arb_ctrl: single-outstanding TL-UL arbiter sharing one RAM between two hosts
module ram_arb_ctrl
  import ram_arb_pkg::*;
  import tlul_pkg::*;
#(
  parameter int WeightI = 1,
  parameter int WeightD = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  tl_h2d_t    tl_corei_i,
  output tl_d2h_t    tl_corei_o,
  input  tl_h2d_t    tl_cored_i,
  output tl_d2h_t    tl_cored_o,
  output tl_h2d_t    tl_ram_o,
  input  tl_d2h_t    tl_ram_i,
  output logic [1:0] gnt_o,
  output logic       busy_o
);
  state_e  state;
  logic    owner, win, act, addr;
  logic [1:0] req;
  tl_h2d_t own_h;
  tl_d2h_t rsp;
  assign req = {tl_cored_i.a_valid, tl_corei_i.a_valid};
  ram_arb_wrr #(.WeightI(WeightI), .WeightD(WeightD)) u_wrr (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req  (req),
    .take (state == IDLE && |req),
    .win  (win)
  );
  // reset gates every handshake output in the same cycle it is asserted
  always_comb begin
    own_h            = owner == HostD ? tl_cored_i : tl_corei_i;
    act              = state != IDLE && !rst_i;
    addr             = act && state == ADDR;
    rsp              = tl_ram_i;
    rsp.a_ready      = addr && tl_ram_i.a_ready;
    tl_ram_o         = act ? own_h : '0;
    tl_ram_o.a_valid = addr && own_h.a_valid;
    tl_corei_o       = act && owner == HostI ? rsp : '0;
    tl_cored_o       = act && owner == HostD ? rsp : '0;
    gnt_o            = act ? (owner == HostD ? 2'b10 : 2'b01) : 2'b00;
    busy_o           = act;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= HostD;
    end else begin
      case (state)
        IDLE: if (|req) begin
          state <= ADDR;
          owner <= win;
        end
        ADDR: if (own_h.a_valid && tl_ram_i.a_ready)
          state <= tl_ram_i.d_valid && own_h.d_ready ? IDLE : RESP;
        RESP: if (tl_ram_i.d_valid && own_h.d_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
